// File: rtl/alu_pipe.sv
// alu_pipe: handshaked RV32/RV64 execute unit with a registered valid/ready result stage.
// Define ALU_MULDIV_EN to add the iterative M-extension multiply/divide engine.
module alu_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            alt,
  input  logic            muldiv,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            busy
);
  localparam int SHW = $clog2(XLEN);
  logic            out_valid_q, out_valid_d, accept, md_op, idle;
  logic [XLEN-1:0] out_q, out_d, base_res;
  logic [SHW-1:0]  shamt;
  assign shamt = y[SHW-1:0];
  assign in_ready = !reset && idle && (!out_valid_q || out_ready);
  assign accept = in_valid && in_ready;
  assign out = out_q;
  assign out_valid = out_valid_q;
  always_comb begin
    case (funct3)
      3'b000:  base_res = alt ? x - y : x + y;
      3'b001:  base_res = x << shamt;
      3'b010:  base_res = {{(XLEN-1){1'b0}}, $signed(x) < $signed(y)};
      3'b011:  base_res = {{(XLEN-1){1'b0}}, x < y};
      3'b100:  base_res = x ^ y;
      3'b101:  base_res = alt ? $unsigned($signed(x) >>> shamt) : x >> shamt;
      3'b110:  base_res = x | y;
      default: base_res = x & y;
    endcase
  end
`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t            state_q, state_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d, rneg_q, rneg_d;
  logic              sx, sy, div0, ovf, ge;
  logic [XLEN-1:0]   xm, ym, spec_res, rsub, fix_res;
  logic [XLEN:0]     add_sum, rsh;
  logic [2*XLEN-1:0] prod, prod_s;
  assign md_op = muldiv;
  assign idle = state_q == IDLE;
  assign busy = !idle;
  // MUL is run unsigned: its low half does not depend on operand signedness
  assign sx = x[XLEN-1] & (funct3[2] ? !funct3[0] : funct3[1] ^ funct3[0]);
  assign sy = y[XLEN-1] & (funct3[2] ? !funct3[0] : funct3[1:0] == 2'b01);
  assign xm = sx ? -x : x;
  assign ym = sy ? -y : y;
  assign div0 = funct3[2] && y == '0;
  assign ovf = funct3[2] && !funct3[0] && x == {1'b1, {(XLEN-1){1'b0}}} && y == '1;
  assign spec_res = div0 ? (funct3[1] ? x : '1) : (funct3[1] ? '0 : x);
  // hi:lo is the product accumulator when multiplying, remainder:quotient when dividing
  assign add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign rsh = {hi_q, lo_q[XLEN-1]};
  assign ge = rsh >= {1'b0, b_q};
  assign rsub = rsh[XLEN-1:0] - b_q;
  assign prod = {hi_q, lo_q};
  assign prod_s = neg_q ? -prod : prod;
  assign fix_res = !op_q[2] ? (op_q[1:0] == 2'b00 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN])
                 : op_q[1] ? (rneg_q ? -hi_q : hi_q) : (neg_q ? -lo_q : lo_q);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    b_d = b_q;
    op_d = op_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    out_d = out_q;
    out_valid_d = out_valid_q & ~out_ready;
    if (accept && (!md_op || div0 || ovf)) begin
      out_d = md_op ? spec_res : base_res;
      out_valid_d = 1'b1;
    end else if (accept) begin
      state_d = RUN;
      cnt_d = SHW'(XLEN - 1);
      hi_d = '0;
      lo_d = xm;
      b_d = ym;
      op_d = funct3;
      neg_d = sx ^ sy;
      rneg_d = sx;
    end else if (state_q == RUN) begin
      state_d = cnt_q == '0 ? FIX : RUN;
      cnt_d = cnt_q - SHW'(1);
      hi_d = op_q[2] ? (ge ? rsub : rsh[XLEN-1:0]) : add_sum[XLEN:1];
      lo_d = op_q[2] ? {lo_q[XLEN-2:0], ge} : {add_sum[0], lo_q[XLEN-1:1]};
    end else if (state_q == FIX) begin
      state_d = IDLE;
      out_d = fix_res;
      out_valid_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    hi_q <= hi_d;
    lo_q <= lo_d;
    b_q <= b_d;
    op_q <= op_d;
    neg_q <= neg_d;
    rneg_q <= rneg_d;
  end
`else
  assign md_op = muldiv & 1'b0;
  assign idle = 1'b1;
  assign busy = 1'b0;
  always_comb begin
    out_d = accept && !md_op ? base_res : out_q;
    out_valid_d = (accept && !md_op) || (out_valid_q && !out_ready);
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q <= out_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against a behavioural scoreboard.
module tb_alu_pipe;
  logic        clk = 0, reset = 1, in_valid = 0, in_ready, alt = 0, md = 0;
  logic        out_valid, out_ready = 1, busy;
  logic [2:0]  f3 = 0;
  logic [31:0] x = 0, y = 0, out;
  int          total = 0, bad = 0, cyc = 0;
  logic        armed = 0, shown = 0, bexp;
  typedef struct {logic [31:0] d; int lat; int stamp;} ent_t;
  ent_t q[$];

  alu_pipe #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .funct3(f3),
    .alt(alt), .muldiv(md), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  function automatic logic md_eff(input logic m);
`ifdef ALU_MULDIV_EN
    return m;
`else
    return 1'b0 & m;
`endif
  endfunction

  function automatic logic [31:0] model(input logic [2:0] f, input logic a, m, input logic [31:0] xa, yb);
    longint sx = longint'($signed(xa)), sy = longint'($signed(yb));
    longint ux = longint'(xa), uy = longint'(yb), p;
    if (!m) begin
      case (f)
        3'd0: return a ? xa - yb : xa + yb;
        3'd1: return xa << yb[4:0];
        3'd2: return {31'b0, sx < sy};
        3'd3: return {31'b0, xa < yb};
        3'd4: return xa ^ yb;
        3'd5: return a ? 32'($signed(xa) >>> yb[4:0]) : xa >> yb[4:0];
        3'd6: return xa | yb;
        default: return xa & yb;
      endcase
    end
    case (f)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: return yb == 0 ? 32'hFFFFFFFF : 32'(sx / sy);
      3'd5: return yb == 0 ? 32'hFFFFFFFF : 32'(ux / uy);
      3'd6: return yb == 0 ? xa : 32'(sx % sy);
      default: return yb == 0 ? xa : 32'(ux % uy);
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f, input logic m, input logic [31:0] xa, yb);
    logic special = f[2] && (yb == 0 || (!f[0] && xa == 32'h80000000 && yb == 32'hFFFFFFFF));
    return (m && !special) ? 33 : 1;
  endfunction

  // Scoreboard: outputs compared each cycle; accepts/drains taken from the inputs seen before the edge.
  always @(negedge clk) begin
    if (armed) begin
      cyc++;
      if (q.size() == 0) check("no_spurious", out_valid, 0);
      else begin
        if (!shown) check("valid_timing", out_valid, (cyc - q[0].stamp) >= q[0].lat);
        else check("hold_valid", out_valid, 1);
        if (out_valid) begin
          check("data", out, q[0].d);
          shown = 1;
        end
      end
      bexp = q.size() != 0 && q[0].lat > 1 && (cyc - q[0].stamp) < q[0].lat;
      check("busy", busy, bexp);
      check("in_ready", in_ready, !reset && !bexp && (!out_valid || out_ready));
      if (reset) begin
        q.delete();
        shown = 0;
      end else begin
        if (out_valid && out_ready && q.size() != 0) begin
          void'(q.pop_front());
          shown = 0;
        end
        if (in_valid && in_ready)
          q.push_back('{model(f3, alt, md_eff(md), x, y), lat_of(f3, md_eff(md), x, y), cyc});
      end
    end
  end

  task automatic offer(input logic [2:0] f, input logic a, m, input logic [31:0] xa, yb);
    int n = 0;
    f3 = f; alt = a; md = m; x = xa; y = yb; in_valid = 1;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    check("accept", in_ready, 1);
    @(posedge clk); #1 in_valid = 0;
  endtask

  task automatic run_op(input string n, input logic [2:0] f, input logic a, m,
                        input logic [31:0] xa, yb, e, input int lat);
    int c = 0;
    out_ready = 1;
    offer(f, a, m, xa, yb);
    do begin @(negedge clk); c++; end while (!out_valid && c < 100);
    check({n, "_lat"}, c, lat);
    check(n, out, e);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    int r = $urandom_range(0, 7);
    return r == 0 ? 32'h80000000 : r == 1 ? 32'hFFFFFFFF : r == 2 ? 32'h0 : r == 3 ? $urandom_range(0, 9) : $urandom;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    armed = 1;
    reset = 0;
    run_op("add_wrap", 3'd0, 0, 0, 32'hFFFFFFFF, 32'h1, 32'h0, 1);
    run_op("sub", 3'd0, 1, 0, 32'd5, 32'd7, 32'hFFFFFFFE, 1);
    run_op("sra", 3'd5, 1, 0, 32'h80000000, 32'h24, 32'hF8000000, 1);
    run_op("srl", 3'd5, 0, 0, 32'h80000000, 32'h24, 32'h08000000, 1);
    run_op("slt", 3'd2, 0, 0, 32'hFFFFFFFF, 32'h1, 32'h1, 1);
    run_op("sltu", 3'd3, 0, 0, 32'hFFFFFFFF, 32'h1, 32'h0, 1);
    run_op("sll", 3'd1, 0, 0, 32'h1, 32'h3F, 32'h80000000, 1);
    run_op("xor", 3'd4, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      f3 = 0; alt = 0; md = 0; x = i; y = 32'h10; in_valid = 1;
      @(negedge clk);
      check("b2b_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1 out_ready = 0;
    offer(3'd0, 0, 0, 32'd3, 32'd4);
    repeat (3) begin
      @(negedge clk);
      check("stall_out", out, 32'd7);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1;
    repeat (2) @(posedge clk);
    #1 out_ready = 0;
    offer(3'd0, 0, 0, 32'd1, 32'd1);
    reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    check("rst_stall_valid", out_valid, 0);
    out_ready = 1;
`ifdef ALU_MULDIV_EN
    run_op("mulh", 3'd1, 0, 1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("div", 3'd4, 0, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_op("rem", 3'd6, 0, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_op("mul", 3'd0, 0, 1, 32'd3, 32'hFFFFFFFE, 32'hFFFFFFFA, 33);
    run_op("mulhu", 3'd3, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("divu0", 3'd5, 0, 1, 32'd9, 32'd0, 32'hFFFFFFFF, 1);
    run_op("rem0", 3'd6, 0, 1, 32'd9, 32'd0, 32'd9, 1);
    run_op("div_ovf", 3'd4, 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    offer(3'd4, 0, 1, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    check("rst_div_valid", out_valid, 0);
    check("rst_div_busy", busy, 0);
    repeat (40) begin
      @(negedge clk);
      check("rst_div_no_result", out_valid, 0);
    end
    @(posedge clk); #1;
`endif
    run_op("add_after_rst", 3'd0, 0, 0, 32'd20, 32'd22, 32'd42, 1);
    for (int i = 0; i < 3000; i++) begin
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 7;
      f3 = 3'($urandom_range(0, 7));
      alt = 1'($urandom_range(0, 1));
      md = $urandom_range(0, 9) < 3;
      x = pick();
      y = pick();
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    c = 0;
    while ((q.size() != 0 || busy) && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
